// File: rtl/alu_pipe_if.sv
// alu_pipe_if: bundles the operand-side and result-side handshakes of one
// alu_pipe execution slot.
//   in_valid/in_ready          operand-side handshake
//   a, b, operationSelect      operands and 12-bit opcode
//   in_tag                     opaque caller tag, returned with the result
//   out_valid/out_ready        result-side handshake
//   q, out_tag, flags          result, its tag, {illegal, zero, carry, overflow}
// modport slave is the ALU's view; modport master is the view of the logic
// that feeds operands and consumes results.
interface alu_pipe_if #(
    parameter int OPERANDSIZE = 64,
    parameter int TAGWIDTH    = 6
);
    logic                   in_valid;
    logic                   in_ready;
    logic [OPERANDSIZE-1:0] a;
    logic [OPERANDSIZE-1:0] b;
    logic [11:0]            operationSelect;
    logic [TAGWIDTH-1:0]    in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [OPERANDSIZE-1:0] q;
    logic [TAGWIDTH-1:0]    out_tag;
    logic [3:0]             flags;

    modport slave (
        input  in_valid, a, b, operationSelect, in_tag, out_ready,
        output in_ready, out_valid, q, out_tag, flags
    );

    modport master (
        output in_valid, a, b, operationSelect, in_tag, out_ready,
        input  in_ready, out_valid, q, out_tag, flags
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined integer ALU with valid/ready on both sides.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; empties the pipeline and clears q,
//        out_tag and flags
//   bus  alu_pipe_if.slave (operand handshake in, result handshake out)
// Opcodes: 0 ADD, 1 XOR, 2 AND, 3 OR, 4 SUB, 5 SLL, 6 SRL, 7 SRA, 8 SLT,
// 9 SLTU; anything else gives q=0 with the illegal flag set and still flows
// through in order. flags = {illegal, zero, carry, overflow}.
// With STAGES>1 the first stage holds operands and the remaining STAGES-1
// stages hold results (the extra ones only delay). With STAGES==1 the result
// is computed straight from the ports and registered once.
module alu_pipe #(
    parameter int OPERANDSIZE = 64,
    parameter int STAGES      = 2,
    parameter int TAGWIDTH    = 6
) (
    input  logic      clk,
    input  logic      rst,
    alu_pipe_if.slave bus
);
    localparam int W    = OPERANDSIZE;
    localparam int SHW  = $clog2(OPERANDSIZE);
    localparam int NRES = (STAGES > 1) ? STAGES - 1 : 1;

    localparam logic [11:0] OP_ADD  = 12'd0;
    localparam logic [11:0] OP_XOR  = 12'd1;
    localparam logic [11:0] OP_AND  = 12'd2;
    localparam logic [11:0] OP_OR   = 12'd3;
    localparam logic [11:0] OP_SUB  = 12'd4;
    localparam logic [11:0] OP_SLL  = 12'd5;
    localparam logic [11:0] OP_SRL  = 12'd6;
    localparam logic [11:0] OP_SRA  = 12'd7;
    localparam logic [11:0] OP_SLT  = 12'd8;
    localparam logic [11:0] OP_SLTU = 12'd9;

    // The whole pipeline moves together; it only freezes when a finished
    // result is waiting on the output and nobody takes it.
    logic stall;
    logic advance;
    assign stall        = bus.out_valid && !bus.out_ready;
    assign advance      = !stall;
    assign bus.in_ready = advance;

    // Operands feeding the combinational ALU.
    logic                src_valid;
    logic [W-1:0]        src_a;
    logic [W-1:0]        src_b;
    logic [11:0]         src_op;
    logic [TAGWIDTH-1:0] src_tag;

    generate
        if (STAGES == 1) begin : g_direct
            assign src_valid = bus.in_valid;
            assign src_a     = bus.a;
            assign src_b     = bus.b;
            assign src_op    = bus.operationSelect;
            assign src_tag   = bus.in_tag;
        end else begin : g_opreg
            logic                valid_reg;
            logic [W-1:0]        a_reg;
            logic [W-1:0]        b_reg;
            logic [11:0]         op_reg;
            logic [TAGWIDTH-1:0] tag_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    a_reg     <= '0;
                    b_reg     <= '0;
                    op_reg    <= '0;
                    tag_reg   <= '0;
                end else if (advance) begin
                    valid_reg <= bus.in_valid;
                    a_reg     <= bus.a;
                    b_reg     <= bus.b;
                    op_reg    <= bus.operationSelect;
                    tag_reg   <= bus.in_tag;
                end
            end

            assign src_valid = valid_reg;
            assign src_a     = a_reg;
            assign src_b     = b_reg;
            assign src_op    = op_reg;
            assign src_tag   = tag_reg;
        end
    endgenerate

    // Combinational ALU. SUB is a + ~b + 1 so its carry-out reads as
    // "no borrow".
    logic [W:0]     sum_ext;
    logic [W:0]     diff_ext;
    logic [SHW-1:0] sh;
    logic [W-1:0]   res_q;
    logic           res_carry;
    logic           res_ovf;
    logic           res_ill;
    logic [3:0]     res_flags;

    assign sum_ext  = {1'b0, src_a} + {1'b0, src_b};
    assign diff_ext = {1'b0, src_a} + {1'b0, ~src_b} + {{W{1'b0}}, 1'b1};
    assign sh       = src_b[SHW-1:0];

    always_comb begin
        res_q     = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        res_ill   = 1'b0;
        case (src_op)
            OP_ADD: begin
                res_q     = sum_ext[W-1:0];
                res_carry = sum_ext[W];
                // Same-sign operands producing an opposite-sign sum.
                res_ovf   = (src_a[W-1] == src_b[W-1]) && (sum_ext[W-1] != src_a[W-1]);
            end
            OP_SUB: begin
                res_q     = diff_ext[W-1:0];
                res_carry = diff_ext[W];
                // Opposite-sign operands where the difference takes b's sign.
                res_ovf   = (src_a[W-1] != src_b[W-1]) && (diff_ext[W-1] != src_a[W-1]);
            end
            OP_XOR:  res_q = src_a ^ src_b;
            OP_AND:  res_q = src_a & src_b;
            OP_OR:   res_q = src_a | src_b;
            OP_SLL:  res_q = src_a << sh;
            OP_SRL:  res_q = src_a >> sh;
            // Kept as its own assignment so the signed context is not lost.
            OP_SRA:  res_q = $signed(src_a) >>> sh;
            OP_SLT:  res_q = {{(W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: res_q = {{(W-1){1'b0}}, (src_a < src_b)};
            default: res_ill = 1'b1;
        endcase
        res_flags = {res_ill, (res_q == '0), res_carry, res_ovf};
    end

    // Result stages; stage 0 captures the ALU output, later stages only
    // delay, and the last one drives the outputs. Bubbles travel as
    // invalid stages.
    logic                stage_valid [NRES];
    logic [W-1:0]        stage_q     [NRES];
    logic [TAGWIDTH-1:0] stage_tag   [NRES];
    logic [3:0]          stage_flags [NRES];

    genvar gi;
    generate
        for (gi = 0; gi < NRES; gi++) begin : g_stage
            logic                valid_reg;
            logic [W-1:0]        q_reg;
            logic [TAGWIDTH-1:0] tag_reg;
            logic [3:0]          flags_reg;
            logic                valid_next;
            logic [W-1:0]        q_next;
            logic [TAGWIDTH-1:0] tag_next;
            logic [3:0]          flags_next;

            if (gi == 0) begin : g_first
                assign valid_next = src_valid;
                assign q_next     = res_q;
                assign tag_next   = src_tag;
                assign flags_next = res_flags;
            end else begin : g_delay
                assign valid_next = stage_valid[gi-1];
                assign q_next     = stage_q[gi-1];
                assign tag_next   = stage_tag[gi-1];
                assign flags_next = stage_flags[gi-1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    q_reg     <= '0;
                    tag_reg   <= '0;
                    flags_reg <= '0;
                end else if (advance) begin
                    valid_reg <= valid_next;
                    q_reg     <= q_next;
                    tag_reg   <= tag_next;
                    flags_reg <= flags_next;
                end
            end

            assign stage_valid[gi] = valid_reg;
            assign stage_q[gi]     = q_reg;
            assign stage_tag[gi]   = tag_reg;
            assign stage_flags[gi] = flags_reg;
        end
    endgenerate

    assign bus.out_valid = stage_valid[NRES-1];
    assign bus.q         = stage_q[NRES-1];
    assign bus.out_tag   = stage_tag[NRES-1];
    assign bus.flags     = stage_flags[NRES-1];
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: two alu_pipe instances, a 64-bit two-stage slot and an 8-bit
// three-stage slot, driven from one process. Directed tables, a backpressure
// sequence, a mid-flight reset and a random stream are checked against a
// scoreboard fed by an arithmetic reference model.
module tb_alu_pipe;
    localparam int ST64 = 2;
    localparam int ST8  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_pipe_if #(.OPERANDSIZE(64), .TAGWIDTH(6)) b64 ();
    alu_pipe_if #(.OPERANDSIZE(8),  .TAGWIDTH(6)) b8 ();

    alu_pipe #(.OPERANDSIZE(64), .STAGES(ST64), .TAGWIDTH(6)) dut64 (
        .clk(clk), .rst(rst), .bus(b64.slave)
    );
    alu_pipe #(.OPERANDSIZE(8), .STAGES(ST8), .TAGWIDTH(6)) dut8 (
        .clk(clk), .rst(rst), .bus(b8.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] q;
        logic [3:0]  f;
    } res_t;

    function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic [11:0] op);
        res_t r;
        logic [64:0] wide;
        logic signed [65:0] sa, sb, exact, wrapped;
        int sh;
        logic ill, c, ov;
        sa = {{2{a[63]}}, a};
        sb = {{2{b[63]}}, b};
        sh = int'(b[5:0]);
        ill = 1'b0; c = 1'b0; ov = 1'b0;
        r.q = '0;
        case (op)
            12'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                r.q = wide[63:0];
                c = wide[64];
                exact = sa + sb;
                wrapped = {{2{r.q[63]}}, r.q};
                ov = (exact != wrapped);
            end
            12'd4: begin
                r.q = a - b;
                c = (a >= b);
                exact = sa - sb;
                wrapped = {{2{r.q[63]}}, r.q};
                ov = (exact != wrapped);
            end
            12'd1: r.q = a ^ b;
            12'd2: r.q = a & b;
            12'd3: r.q = a | b;
            12'd5: r.q = a << sh;
            12'd6: r.q = a >> sh;
            12'd7: r.q = $signed(a) >>> sh;
            12'd8: r.q = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            12'd9: r.q = (a < b) ? 64'd1 : 64'd0;
            default: ill = 1'b1;
        endcase
        r.f = {ill, (r.q == 64'd0), c, ov};
        return r;
    endfunction

    // ---------------- 64-bit scoreboard stepping ----------------
    typedef struct {
        logic [63:0] q;
        logic [5:0]  tag;
        logic [3:0]  f;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_out = 0;
    int   ir_low = 0;
    bit   chk_lat = 1'b0;
    bit   prev_held = 1'b0;
    logic [63:0] held_q;
    logic [5:0]  held_tag;
    logic [3:0]  held_f;

    // One cycle on the 64-bit slot: drive, let it settle, check, then move
    // to the next falling edge.
    task automatic step(input logic iv, input logic [63:0] ia, input logic [63:0] ib,
                        input logic [11:0] iop, input logic [5:0] itag,
                        input logic ordy, output logic acc);
        exp_t e;
        res_t m;
        b64.in_valid = iv;
        b64.a = ia;
        b64.b = ib;
        b64.operationSelect = iop;
        b64.in_tag = itag;
        b64.out_ready = ordy;
        #1;
        chk(b64.in_ready === !(b64.out_valid && !ordy), "in_ready_rule",
            $sformatf("got %b want %b", b64.in_ready, !(b64.out_valid && !ordy)));
        if (b64.in_ready !== 1'b1) ir_low++;
        if (prev_held)
            chk(b64.out_valid === 1'b1 && b64.q === held_q && b64.out_tag === held_tag
                && b64.flags === held_f, "hold_stable",
                $sformatf("got v=%b q=%h tag=%0d f=%b want v=1 q=%h tag=%0d f=%b",
                          b64.out_valid, b64.q, b64.out_tag, b64.flags,
                          held_q, held_tag, held_f));
        if (b64.out_valid && ordy) begin
            chk(sb.size() != 0, "unexpected_out",
                $sformatf("got tag=%0d q=%h with nothing outstanding, want none",
                          b64.out_tag, b64.q));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_out++;
                $display("out tag=%0d q=%h flags=%b", b64.out_tag, b64.q, b64.flags);
                chk(b64.q === e.q && b64.out_tag === e.tag && b64.flags === e.f, "result",
                    $sformatf("got q=%h tag=%0d f=%b want q=%h tag=%0d f=%b",
                              b64.q, b64.out_tag, b64.flags, e.q, e.tag, e.f));
                if (chk_lat)
                    chk(cyc - e.cyc == ST64, "latency",
                        $sformatf("got %0d want %0d", cyc - e.cyc, ST64));
            end
        end
        acc = iv && (b64.in_ready === 1'b1);
        if (acc) begin
            m = model(ia, ib, iop);
            e.q = m.q; e.f = m.f; e.tag = itag; e.cyc = cyc;
            sb.push_back(e);
        end
        prev_held = b64.out_valid && !ordy;
        held_q = b64.q; held_tag = b64.out_tag; held_f = b64.flags;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 30 && sb.size() != 0; i++)
            step(1'b0, 64'd0, 64'd0, 12'd0, 6'd0, 1'b1, acc);
        chk(sb.size() == 0, "drain", $sformatf("got %0d outstanding want 0", sb.size()));
    endtask

    // ---------------- 8-bit directed ----------------
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [11:0] op,
                        input logic [7:0] eq, input logic [3:0] ef, input string nm);
        int lat;
        b8.a = a; b8.b = b; b8.operationSelect = op; b8.in_tag = 6'h2A;
        b8.in_valid = 1'b1; b8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b8.in_valid = 1'b0;
        lat = 1;
        while (b8.out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        $display("op8 %s q=%h flags=%b latency=%0d", nm, b8.q, b8.flags, lat);
        chk(b8.out_valid === 1'b1 && b8.q === eq && b8.flags === ef && b8.out_tag === 6'h2A
            && lat == ST8, nm,
            $sformatf("got v=%b q=%h f=%b tag=%h lat=%0d want v=1 q=%h f=%b tag=2a lat=%0d",
                      b8.out_valid, b8.q, b8.flags, b8.out_tag, lat, eq, ef, ST8));
    endtask

    typedef struct {
        logic [7:0]  a, b;
        logic [11:0] op;
        logic [7:0]  q;
        logic [3:0]  f;
        string       name;
    } vec8_t;

    typedef struct {
        logic [63:0] a, b;
        logic [11:0] op;
        logic [5:0]  tag;
        logic [63:0] q;
        logic [3:0]  f;
    } vec64_t;

    vec8_t  t8[5];
    vec64_t t64[12];

    function automatic logic [63:0] pick64();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   idx, base_out, base_low;
        logic [5:0] tag;
        exp_t e;

        t8[0] = '{8'h7F, 8'h01, 12'd0, 8'h80, 4'b0001, "add8_ovf"};
        t8[1] = '{8'hFF, 8'h01, 12'd0, 8'h00, 4'b0110, "add8_carry"};
        t8[2] = '{8'h00, 8'h01, 12'd4, 8'hFF, 4'b0000, "sub8_borrow"};
        t8[3] = '{8'h80, 8'h01, 12'd4, 8'h7F, 4'b0011, "sub8_ovf"};
        t8[4] = '{8'h01, 8'h0F, 12'd5, 8'h80, 4'b0000, "sll8_mask"};

        t64[0]  = '{64'd5, 64'd7, 12'd0, 6'd3, 64'd12, 4'b0000};
        t64[1]  = '{64'h8000_0000_0000_0000, 64'h43, 12'd7, 6'd4, 64'hF000_0000_0000_0000, 4'b0000};
        t64[2]  = '{'1, 64'd1, 12'd8, 6'd5, 64'd1, 4'b0000};
        t64[3]  = '{'1, 64'd1, 12'd9, 6'd6, 64'd0, 4'b0100};
        t64[4]  = '{64'd123, 64'd456, 12'd12, 6'd9, 64'd0, 4'b1100};
        t64[5]  = '{64'd5, 64'd5, 12'd4, 6'd10, 64'd0, 4'b0110};
        t64[6]  = '{64'd1, 64'd63, 12'd5, 6'd11, 64'h8000_0000_0000_0000, 4'b0000};
        t64[7]  = '{64'h8000_0000_0000_0000, 64'h7F, 12'd6, 6'd12, 64'd1, 4'b0000};
        t64[8]  = '{64'hF0F0, 64'hFF00, 12'd1, 6'd13, 64'h0FF0, 4'b0000};
        t64[9]  = '{64'hF0F0, 64'hFF00, 12'd2, 6'd14, 64'hF000, 4'b0000};
        t64[10] = '{64'hF0F0, 64'hFF00, 12'd3, 6'd15, 64'hFFF0, 4'b0000};
        t64[11] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 12'd0, 6'd16, 64'h8000_0000_0000_0000, 4'b0001};

        b64.in_valid = 1'b0; b64.a = '0; b64.b = '0; b64.operationSelect = '0;
        b64.in_tag = '0; b64.out_ready = 1'b1;
        b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.operationSelect = '0;
        b8.in_tag = '0; b8.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk(b64.out_valid === 1'b0 && b64.in_ready === 1'b1 && b64.q === 64'd0
            && b64.out_tag === 6'd0 && b64.flags === 4'd0, "reset64",
            $sformatf("got v=%b rdy=%b q=%h tag=%0d f=%b want 0 1 0 0 0",
                      b64.out_valid, b64.in_ready, b64.q, b64.out_tag, b64.flags));
        chk(b8.out_valid === 1'b0 && b8.in_ready === 1'b1 && b8.q === 8'd0
            && b8.flags === 4'd0, "reset8",
            $sformatf("got v=%b rdy=%b q=%h f=%b want 0 1 0 0",
                      b8.out_valid, b8.in_ready, b8.q, b8.flags));
        @(negedge clk);

        // 8-bit edge cases.
        for (int i = 0; i < 5; i++)
            run8(t8[i].a, t8[i].b, t8[i].op, t8[i].q, t8[i].f, t8[i].name);

        // 64-bit directed table, back to back, with latency checks.
        chk_lat = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, t64[i].a, t64[i].b, t64[i].op, t64[i].tag, 1'b1, acc);
            e = sb[sb.size()-1];
            chk(e.q === t64[i].q && e.f === t64[i].f, "table_model",
                $sformatf("vec %0d model q=%h f=%b want q=%h f=%b", i, e.q, e.f,
                          t64[i].q, t64[i].f));
            sb[sb.size()-1].q = t64[i].q;
            sb[sb.size()-1].f = t64[i].f;
        end
        drain();
        chk_lat = 1'b0;

        // Backpressure: ten ops, out_ready low for five cycles mid-stream.
        base_out = n_out;
        base_low = ir_low;
        idx = 0;
        for (int s = 0; s < 40 && idx < 10; s++) begin
            step(1'b1, pick64(), pick64(), 12'(idx % 10), 6'(idx),
                 !(s >= 4 && s < 9), acc);
            if (acc) idx++;
        end
        drain();
        chk(n_out - base_out == 10, "bp_count",
            $sformatf("got %0d want 10", n_out - base_out));
        chk(ir_low - base_low == 5, "bp_stall_cycles",
            $sformatf("got %0d want 5", ir_low - base_low));

        // Reset with two operations in flight.
        step(1'b1, 64'd1, 64'd2, 12'd0, 6'd33, 1'b1, acc);
        step(1'b1, 64'd3, 64'd4, 12'd12, 6'd34, 1'b1, acc);
        b64.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk(b64.out_valid === 1'b0 && b64.flags === 4'd0 && b64.q === 64'd0, "reset_mid",
            $sformatf("got v=%b f=%b q=%h want 0 0 0", b64.out_valid, b64.flags, b64.q));
        sb.delete();
        prev_held = 1'b0;
        @(negedge clk);
        base_out = n_out;
        for (int i = 0; i < 8; i++)
            step(1'b0, 64'd0, 64'd0, 12'd0, 6'd0, 1'b1, acc);
        chk(n_out == base_out, "reset_discard",
            $sformatf("got %0d outputs want 0", n_out - base_out));

        // Random stream with random bubbles and backpressure.
        tag = 6'd0;
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), pick64(), pick64(),
                 ($urandom_range(0, 7) == 0) ? 12'($urandom_range(10, 4095))
                                              : 12'($urandom_range(0, 9)),
                 tag, ($urandom_range(0, 2) != 0), acc);
            if (acc) tag = tag + 6'd1;
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
